spi_cmd_arbiter: RTL and testbench
==================================

Name: spi_cmd_arbiter

Overview:
- Shares the single 9-bit SPI write engine (en/data/done interface) between NUM_REQ word-level requesters, e.g. init sequencer, RGB fill, picture streamer.
- Also owns the panel hardware-reset channel.
- Round-robin arbitration, with a burst lock so a command plus its data stream is never interleaved with another requester.
- Per-transfer done watchdog, so a hung engine cannot deadlock the display pipeline.

Parameters:
- NUM_REQ, 3, number of word requesters (2..8).
- TIMEOUT_CYC, 1_000_000, cycles to wait for an engine done before aborting the transfer.
- IDX_W, 3, width of the grant index (must satisfy 2**IDX_W >= NUM_REQ).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_i  in  NUM_REQ  per-requester word request
- word_i  in  9*NUM_REQ  per-requester word; bit 8 = D/C (1 data, 0 command); slice k = [9k+8:9k]
- lock_i  in  NUM_REQ  sampled with the word; 1 = keep the grant for this requester's next word
- ack_o  out  NUM_REQ  one-cycle pulse: the requester's word has completed (or aborted)
- err_o  out  1  one-cycle pulse alongside ack_o when the transfer timed out
- gnt_idx_o  out  IDX_W  index of the current or last owner
- busy_o  out  1  1 whenever the state is not IDLE
- hwrst_req_i  in  1  request a panel hardware-reset pulse
- hwrst_ack_o  out  1  one-cycle pulse when the reset sequence is done
- en_o  out  2  engine strobes: [0] reset sequence, [1] write word; one-cycle pulses
- data_o  out  9  word presented to the engine; held stable from the en_o[1] cycle until done
- done_i  in  2  engine completion pulses: [0] reset done, [1] write done

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; en_o=0, data_o=0, ack_o=0, err_o=0, hwrst_ack_o=0, busy_o=0, gnt_idx_o=0; rr pointer=0; lock=0; timer=0.
- Reset mid-transfer aborts it silently: no ack is issued. A late done_i arriving after reset is ignored in IDLE.
- States: IDLE, ISSUE, WAIT_W, RST_ISSUE, RST_WAIT.
- IDLE, priority order:
  - hwrst_req_i -> RST_ISSUE. Not taken while lock is held.
  - Else, lock held and req_i[owner] -> ISSUE with the same owner.
  - Else, lock held and no owner request -> stay IDLE. Other requesters stay blocked.
  - Else, any req_i -> round-robin pick of the first asserted index at or after rr pointer, wrapping modulo NUM_REQ -> ISSUE.
- ISSUE: one cycle.
  - en_o[1]=1; data_o=word_i[owner]; latch lock_i[owner]; gnt_idx_o=owner; timer cleared -> WAIT_W.
- WAIT_W: en_o=0; data_o held; timer increments.
  - done_i[1]: ack_o[owner]=1 for 1 cycle; rr pointer=owner+1 (wrap); lock=latched lock_i -> IDLE.
  - timer==TIMEOUT_CYC-1 without done: ack_o[owner]=1 and err_o=1; lock cleared; rr pointer advances -> IDLE.
  - done_i[1] and timeout in the same cycle: done wins; no err.
- RST_ISSUE: en_o[0]=1 for one cycle -> RST_WAIT.
- RST_WAIT:
  - done_i[0] -> hwrst_ack_o=1 -> IDLE.
  - Timeout -> hwrst_ack_o=1 and err_o=1 -> IDLE.
  - A hwrst_req_i that stays high re-triggers.
- Latency: req_i high in IDLE -> en_o[1] on the next cycle. ack_o occurs the cycle after done_i[1]. Best case is 1 IDLE turnaround cycle per word.
- Requester rule: hold req_i, word_i and lock_i stable until ack_o. Drop req_i in the ack cycle, or keep it high with the next word.
- Dropping req_i before ack is legal; the transfer still completes and acks.
- done_i pulses in IDLE or ISSUE, and done_i[0] in WAIT_W, are ignored.
- A single requester may stream back-to-back words: lock is irrelevant when there is no contention.
- Protocol error: lock_i must not be set on a word whose owner then stops requesting. The only recovery is timeout or reset; lock does not time out in IDLE.

Test Plan:
- Single requester: req_i=001, word_i[0]=9'h02C, done_i[1] 5 cycles after en_o[1] -> en_o[1] one cycle after req; data_o=9'h02C held through done; ack_o=001 one cycle after done; err_o=0.
- Round robin: req_i=111 held, done 2 cycles after each en_o[1] -> gnt_idx_o sequence 0,1,2,0; each ack_o bit pulses once per word.
- Burst lock: requester 2 sends 9'h02C with lock=1 then four 9'h1xx words, the last with lock=0, while req_i[0] is held -> no grant to 0 until requester 2's fifth ack; then gnt_idx_o=0.
- Reset priority: hwrst_req_i and req_i=010 asserted together in IDLE -> en_o=01 first; hwrst_ack_o after done_i[0]; then en_o=10 with word_i[1].
- Timeout: TIMEOUT_CYC=16, no done_i -> ack_o[owner] and err_o pulse exactly 16 cycles after the ISSUE cycle; the next requester is then served.
- Sync reset mid-WAIT_W: assert rst for 1 cycle, then apply done_i[1] -> all outputs 0; no ack_o; state IDLE; rr pointer 0.

Source files
------------

// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter sharing one 9-bit SPI write engine and the panel reset channel; burst lock keeps command+data streams together.
// en_o[1] one cycle after req_i in IDLE, ack_o one cycle after done_i[1]; requesters hold req/word/lock until ack, a stuck engine is aborted by the done watchdog.
module spi_cmd_arbiter #(
   parameter int NUM_REQ     = 3,
   parameter int TIMEOUT_CYC = 1_000_000,
   parameter int IDX_W       = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_i,
   input  logic [9*NUM_REQ-1:0] word_i,
   input  logic [NUM_REQ-1:0]   lock_i,
   output logic [NUM_REQ-1:0]   ack_o,
   output logic                 err_o,
   output logic [IDX_W-1:0]     gnt_idx_o,
   output logic                 busy_o,
   input  logic                 hwrst_req_i,
   output logic                 hwrst_ack_o,
   output logic [1:0]           en_o,
   output logic [8:0]           data_o,
   input  logic [1:0]           done_i
);

   localparam int NP = 2**IDX_W;
   localparam int TW = $clog2(TIMEOUT_CYC) + 1;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_W, RST_ISSUE, RST_WAIT} state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   owner, owner_nxt, rr_ptr, rr_nxt, pick, owner_inc;
   logic               pick_vld;
   logic               lock, lock_nxt, lock_lat, lock_lat_nxt;
   logic [TW-1:0]      timer, timer_nxt;
   logic               tmo;
   logic [8:0]         data_q, data_nxt;
   logic [NUM_REQ-1:0] ack_q, ack_nxt, owner_hot;
   logic               err_q, err_nxt, hwack_q, hwack_nxt;

   // Pad per-requester inputs to a power of two so any IDX_W index is in range.
   logic [NP-1:0] req_pad, lock_pad;
   logic [8:0]    word_arr [NP];

   for (genvar g = 0; g < NP; g++) begin : g_pad
      if (g < NUM_REQ) begin : g_real
         assign req_pad[g]  = req_i[g];
         assign lock_pad[g] = lock_i[g];
         assign word_arr[g] = word_i[9*g +: 9];
      end else begin : g_zero
         assign req_pad[g]  = 1'b0;
         assign lock_pad[g] = 1'b0;
         assign word_arr[g] = 9'h000;
      end
   end

   // Scan from the highest offset down so the nearest request at/after rr_ptr wins.
   always_comb begin
      int j;
      pick     = '0;
      pick_vld = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         j = int'(rr_ptr) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (req_pad[IDX_W'(j)]) begin
            pick     = IDX_W'(j);
            pick_vld = 1'b1;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) owner_hot[k] = (owner == IDX_W'(k));
   end

   assign owner_inc = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
   assign tmo       = (timer == TW'(TIMEOUT_CYC - 1));

   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner;
      rr_nxt       = rr_ptr;
      lock_nxt     = lock;
      lock_lat_nxt = lock_lat;
      timer_nxt    = timer + TW'(1);
      data_nxt     = data_q;
      ack_nxt      = '0;
      err_nxt      = 1'b0;
      hwack_nxt    = 1'b0;
      case (state)
         IDLE: begin
            timer_nxt = '0;
            if (hwrst_req_i && !lock) begin
               state_nxt = RST_ISSUE;
            end else if (lock) begin
               if (req_pad[owner]) begin
                  state_nxt = ISSUE;
                  data_nxt  = word_arr[owner];
               end
            end else if (pick_vld) begin
               state_nxt = ISSUE;
               owner_nxt = pick;
               data_nxt  = word_arr[pick];
            end
         end
         ISSUE: begin
            lock_lat_nxt = lock_pad[owner];
            state_nxt    = WAIT_W;
         end
         WAIT_W: begin
            if (done_i[1]) begin
               ack_nxt   = owner_hot;
               rr_nxt    = owner_inc;
               lock_nxt  = lock_lat;
               state_nxt = IDLE;
            end else if (tmo) begin
               ack_nxt   = owner_hot;
               err_nxt   = 1'b1;
               rr_nxt    = owner_inc;
               lock_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end
         RST_ISSUE: state_nxt = RST_WAIT;
         RST_WAIT: begin
            if (done_i[0]) begin
               hwack_nxt = 1'b1;
               state_nxt = IDLE;
            end else if (tmo) begin
               hwack_nxt = 1'b1;
               err_nxt   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         owner    <= '0;
         rr_ptr   <= '0;
         lock     <= 1'b0;
         lock_lat <= 1'b0;
         timer    <= '0;
         data_q   <= '0;
         ack_q    <= '0;
         err_q    <= 1'b0;
         hwack_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         rr_ptr   <= rr_nxt;
         lock     <= lock_nxt;
         lock_lat <= lock_lat_nxt;
         timer    <= timer_nxt;
         data_q   <= data_nxt;
         ack_q    <= ack_nxt;
         err_q    <= err_nxt;
         hwack_q  <= hwack_nxt;
      end
   end

   assign en_o        = {state == ISSUE, state == RST_ISSUE};
   assign busy_o      = (state != IDLE);
   assign data_o      = data_q;
   assign gnt_idx_o   = owner;
   assign ack_o       = ack_q;
   assign err_o       = err_q;
   assign hwrst_ack_o = hwack_q;

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Scoreboard bench for spi_cmd_arbiter: expected grants queued with the stimulus, checked when en_o[1] fires.
module tb_spi_cmd_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req_i = '0;
   logic [26:0] word_i = '0;
   logic [2:0]  lock_i = '0;
   logic [2:0]  ack_o;
   logic        err_o;
   logic [2:0]  gnt_idx_o;
   logic        busy_o;
   logic        hwrst_req_i = 1'b0;
   logic        hwrst_ack_o;
   logic [1:0]  en_o;
   logic [8:0]  data_o;
   logic [1:0]  done_i = '0;

   int total = 0;
   int bad   = 0;
   int ack_cnt = 0;

   typedef struct packed {
      logic [2:0] idx;
      logic [8:0] word;
   } exp_t;
   exp_t exp_q[$];

   spi_cmd_arbiter #(.NUM_REQ(3), .TIMEOUT_CYC(16), .IDX_W(3)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .word_i(word_i), .lock_i(lock_i),
      .ack_o(ack_o), .err_o(err_o), .gnt_idx_o(gnt_idx_o), .busy_o(busy_o),
      .hwrst_req_i(hwrst_req_i), .hwrst_ack_o(hwrst_ack_o), .en_o(en_o),
      .data_o(data_o), .done_i(done_i)
   );

   always #5 clk = ~clk;

   always @(negedge clk) ack_cnt += $countones(ack_o);

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
      $fatal(1, "bench timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_word(input int k, input logic [8:0] w);
      word_i[9*k +: 9] = w;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_i = '0; lock_i = '0; hwrst_req_i = 1'b0; done_i = '0;
      exp_q.delete();
      tick(); tick();
      rst = 1'b0;
   endtask

   // Waits for a write strobe, checks it against the queued expectation, answers with done after lat cycles.
   // Returns in the ack cycle so the caller can present the next word or drop req_i.
   task automatic serve_word(input int lat, output int waited);
      bit ok = 1'b0;
      exp_t e;
      logic [2:0] a_exp;
      waited = 0;
      while (!ok && waited < 40) begin
         if (en_o[1]) ok = 1'b1;
         else begin tick(); waited++; end
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL grant_wait: no en_o[1] within %0d cycles, required a write strobe", waited);
         return;
      end
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_grant: gnt_idx_o=%0d data_o=%h, required no grant", gnt_idx_o, data_o);
         return;
      end
      e = exp_q.pop_front();
      total++;
      if (gnt_idx_o !== e.idx) begin
         bad++;
         $display("FAIL grant_idx: gnt_idx_o=%0d, required %0d", gnt_idx_o, e.idx);
      end
      total++;
      if (data_o !== e.word) begin
         bad++;
         $display("FAIL grant_data: data_o=%h, required %h", data_o, e.word);
      end
      repeat (lat) tick();
      total++;
      if (data_o !== e.word || ack_o !== 3'b000) begin
         bad++;
         $display("FAIL data_hold: data_o=%h ack_o=%b, required %h and 000", data_o, ack_o, e.word);
      end
      done_i = 2'b10;
      tick();
      done_i = 2'b00;
      a_exp = 3'b001 << e.idx;
      total++;
      if (ack_o !== a_exp || err_o !== 1'b0) begin
         bad++;
         $display("FAIL word_ack: ack_o=%b err_o=%b, required %b and 0", ack_o, err_o, a_exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      total++;
      if ({en_o, data_o, ack_o, err_o, hwrst_ack_o, busy_o, gnt_idx_o} !== 20'd0) begin
         bad++;
         $display("FAIL reset_state: en=%b data=%h ack=%b err=%b hwack=%b busy=%b gnt=%0d, required all 0",
                  en_o, data_o, ack_o, err_o, hwrst_ack_o, busy_o, gnt_idx_o);
      end
   endtask

   task automatic test_single();
      int w;
      do_reset();
      set_word(0, 9'h02C); req_i = 3'b001;
      exp_q.push_back('{idx: 3'd0, word: 9'h02C});
      serve_word(5, w);
      total++;
      if (w != 1) begin
         bad++;
         $display("FAIL single_latency: en_o[1] after %0d cycles, required 1", w);
      end
      req_i = 3'b000;
      tick();
      total++;
      if (ack_o !== 3'b000 || busy_o !== 1'b0) begin
         bad++;
         $display("FAIL single_idle: ack_o=%b busy_o=%b, required 000 and 0", ack_o, busy_o);
      end
   endtask

   task automatic test_back_to_back();
      int w;
      do_reset();
      set_word(0, 9'h100); req_i = 3'b001;
      exp_q.push_back('{idx: 3'd0, word: 9'h100});
      serve_word(1, w);
      for (int i = 1; i < 4; i++) begin
         set_word(0, 9'h100 + 9'(i));
         exp_q.push_back('{idx: 3'd0, word: 9'h100 + 9'(i)});
         serve_word(1, w);
         total++;
         if (w != 1) begin
            bad++;
            $display("FAIL b2b_turnaround: word %0d strobe after %0d cycles, required 1", i, w);
         end
      end
      req_i = 3'b000;
   endtask

   task automatic test_round_robin();
      int w;
      int acks0;
      do_reset();
      set_word(0, 9'h011); set_word(1, 9'h122); set_word(2, 9'h033);
      exp_q.push_back('{idx: 3'd0, word: 9'h011});
      exp_q.push_back('{idx: 3'd1, word: 9'h122});
      exp_q.push_back('{idx: 3'd2, word: 9'h033});
      exp_q.push_back('{idx: 3'd0, word: 9'h044});
      acks0 = ack_cnt;
      req_i = 3'b111;
      serve_word(2, w);
      set_word(0, 9'h044);
      serve_word(2, w);
      serve_word(2, w);
      serve_word(2, w);
      req_i = 3'b000;
      tick(); tick();
      total++;
      if (ack_cnt - acks0 != 4 || busy_o !== 1'b0) begin
         bad++;
         $display("FAIL rr_ack_count: acks=%0d busy=%b, required 4 and 0", ack_cnt - acks0, busy_o);
      end
   endtask

   task automatic test_burst_lock();
      int w;
      do_reset();
      set_word(2, 9'h02C); lock_i = 3'b100; req_i = 3'b100;
      exp_q.push_back('{idx: 3'd2, word: 9'h02C});
      tick();
      set_word(0, 9'h0AA); req_i = 3'b101;
      serve_word(2, w);
      for (int i = 1; i <= 4; i++) begin
         set_word(2, 9'h100 + 9'(i));
         lock_i = (i == 4) ? 3'b000 : 3'b100;
         exp_q.push_back('{idx: 3'd2, word: 9'h100 + 9'(i)});
         serve_word(2, w);
      end
      req_i = 3'b001;
      exp_q.push_back('{idx: 3'd0, word: 9'h0AA});
      serve_word(2, w);
      req_i = 3'b000;
      tick();
   endtask

   task automatic test_reset_priority();
      int w;
      do_reset();
      set_word(1, 9'h155); req_i = 3'b010; hwrst_req_i = 1'b1;
      tick();
      total++;
      if (en_o !== 2'b01) begin
         bad++;
         $display("FAIL hwrst_first: en_o=%b, required 01", en_o);
      end
      tick();
      total++;
      if (en_o !== 2'b00 || busy_o !== 1'b1) begin
         bad++;
         $display("FAIL hwrst_pulse: en_o=%b busy=%b, required 00 and 1", en_o, busy_o);
      end
      tick();
      done_i = 2'b01; hwrst_req_i = 1'b0;
      total++;
      if (hwrst_ack_o !== 1'b0) begin
         bad++;
         $display("FAIL hwrst_early: hwrst_ack_o=%b, required 0", hwrst_ack_o);
      end
      tick();
      done_i = 2'b00;
      total++;
      if (hwrst_ack_o !== 1'b1 || err_o !== 1'b0) begin
         bad++;
         $display("FAIL hwrst_ack: hwrst_ack_o=%b err_o=%b, required 1 and 0", hwrst_ack_o, err_o);
      end
      exp_q.push_back('{idx: 3'd1, word: 9'h155});
      serve_word(2, w);
      req_i = 3'b000;
      tick();
   endtask

   task automatic test_timeout();
      int w;
      bit early = 1'b0;
      do_reset();
      set_word(0, 9'h0C3); set_word(1, 9'h13C); req_i = 3'b011;
      tick();
      total++;
      if (en_o !== 2'b10 || data_o !== 9'h0C3) begin
         bad++;
         $display("FAIL tmo_issue: en_o=%b data_o=%h, required 10 and 0c3", en_o, data_o);
      end
      for (int i = 1; i < 16; i++) begin
         tick();
         if (ack_o !== 3'b000 || err_o !== 1'b0) early = 1'b1;
      end
      total++;
      if (early) begin
         bad++;
         $display("FAIL tmo_early: ack/err seen before cycle 16, required none");
      end
      tick();
      total++;
      if (ack_o !== 3'b001 || err_o !== 1'b1) begin
         bad++;
         $display("FAIL tmo_abort: ack_o=%b err_o=%b at cycle 16, required 001 and 1", ack_o, err_o);
      end
      req_i = 3'b010;
      exp_q.push_back('{idx: 3'd1, word: 9'h13C});
      serve_word(2, w);
      req_i = 3'b000;
      tick();
   endtask

   task automatic test_reset_mid_wait();
      int w;
      do_reset();
      set_word(0, 9'h0F0); req_i = 3'b001;
      exp_q.push_back('{idx: 3'd0, word: 9'h0F0});
      serve_word(2, w);
      set_word(1, 9'h1E1); req_i = 3'b010;
      tick(); tick();
      total++;
      if (busy_o !== 1'b1 || gnt_idx_o !== 3'd1) begin
         bad++;
         $display("FAIL midrst_setup: busy=%b gnt=%0d, required 1 and 1", busy_o, gnt_idx_o);
      end
      rst = 1'b1; req_i = 3'b000;
      tick();
      rst = 1'b0; done_i = 2'b11;
      total++;
      if ({en_o, data_o, ack_o, err_o, hwrst_ack_o, busy_o, gnt_idx_o} !== 20'd0) begin
         bad++;
         $display("FAIL midrst_state: en=%b data=%h ack=%b err=%b hwack=%b busy=%b gnt=%0d, required all 0",
                  en_o, data_o, ack_o, err_o, hwrst_ack_o, busy_o, gnt_idx_o);
      end
      tick();
      done_i = 2'b00;
      tick();
      total++;
      if (ack_o !== 3'b000 || err_o !== 1'b0 || busy_o !== 1'b0) begin
         bad++;
         $display("FAIL midrst_late_done: ack=%b err=%b busy=%b, required 000 0 0", ack_o, err_o, busy_o);
      end
      set_word(0, 9'h0A5); set_word(1, 9'h15A); req_i = 3'b011;
      exp_q.push_back('{idx: 3'd0, word: 9'h0A5});
      serve_word(2, w);
      req_i = 3'b000;
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_round_robin();
      test_burst_lock();
      test_reset_priority();
      test_timeout();
      test_reset_mid_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
